// File: rtl/mdio_scan_pkg.sv
// Shared state encodings, line payload and ASCII helpers for the MDIO register scanner.
package mdio_scan_pkg;

   localparam int unsigned ADDR_W     = 5;
   localparam int unsigned DATA_W     = 16;
   localparam int unsigned CHAR_IDX_W = 3;
   localparam int unsigned LINE_LEN   = 8;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_FIND = 3'd1;
   localparam logic [2:0] ST_REQ  = 3'd2;
   localparam logic [2:0] ST_WAIT = 3'd3;
   localparam logic [2:0] ST_EMIT = 3'd4;
   localparam logic [2:0] ST_DONE = 3'd5;

   localparam logic [7:0] CHAR_COLON = 8'h3A;
   localparam logic [7:0] CHAR_NL    = 8'h0A;
   localparam logic [7:0] CHAR_X     = 8'h58;

   // One register line: address, read data and whether the read timed out.
   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      logic              timeout;
   } line_t;

   // Uppercase ASCII hex digit for a nibble.
   function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
      if (nib < 4'd10) hex_ascii = 8'h30 + 8'(nib);
      else             hex_ascii = 8'h37 + 8'(nib);
   endfunction

endpackage

// File: rtl/mdio_reg_scanner_line_serializer.sv
// Turns one register line payload into "AA:DDDD\n" over a byte valid/ready handshake.
module line_serializer
   import mdio_scan_pkg::*;
(
   input  logic       clk,
   input  logic       i_reset,
   input  logic       line_load,
   input  line_t      line_in,
   output logic [7:0] o_byte,
   output logic       o_byte_valid,
   input  logic       i_byte_ready,
   output logic       line_done
);

   line_t                 line_q;
   logic [CHAR_IDX_W-1:0] char_idx;
   logic                  xfer_c;
   logic                  last_c;

   // Character at position idx of the line held in l.
   function automatic logic [7:0] char_at(input line_t l, input logic [CHAR_IDX_W-1:0] idx);
      case (idx)
         3'd0:    char_at = hex_ascii({3'b000, l.addr[4]});
         3'd1:    char_at = hex_ascii(l.addr[3:0]);
         3'd2:    char_at = CHAR_COLON;
         3'd3:    char_at = l.timeout ? CHAR_X : hex_ascii(l.data[15:12]);
         3'd4:    char_at = l.timeout ? CHAR_X : hex_ascii(l.data[11:8]);
         3'd5:    char_at = l.timeout ? CHAR_X : hex_ascii(l.data[7:4]);
         3'd6:    char_at = l.timeout ? CHAR_X : hex_ascii(l.data[3:0]);
         default: char_at = CHAR_NL;
      endcase
   endfunction

   assign xfer_c = o_byte_valid && i_byte_ready;
   assign last_c = (char_idx == CHAR_IDX_W'(LINE_LEN - 1));

   // Load a line, then advance one character per accepted transfer; byte holds while stalled.
   always_ff @(posedge clk) begin
      if (i_reset) begin
         line_q       <= '0;
         char_idx     <= '0;
         o_byte       <= '0;
         o_byte_valid <= 1'b0;
         line_done    <= 1'b0;
      end else begin
         line_done <= 1'b0;
         if (line_load) begin
            line_q       <= line_in;
            char_idx     <= '0;
            o_byte       <= char_at(line_in, '0);
            o_byte_valid <= 1'b1;
         end else if (xfer_c) begin
            if (last_c) begin
               o_byte_valid <= 1'b0;
               char_idx     <= '0;
               line_done    <= 1'b1;
            end else begin
               char_idx <= char_idx + CHAR_IDX_W'(1);
               o_byte   <= char_at(line_q, char_idx + CHAR_IDX_W'(1));
            end
         end
      end
   end

endmodule

// File: rtl/mdio_reg_scanner.sv
// Scans a selectable set of MDIO PHY registers and streams one ASCII line per register.
module mdio_reg_scanner
   import mdio_scan_pkg::*;
#(
   parameter int unsigned PERIOD_CYCLES  = 1_000_000,
   parameter int unsigned TIMEOUT_CYCLES = 4096,
   parameter int unsigned TIMER_WIDTH    = $clog2(PERIOD_CYCLES) + 1
) (
   input  logic        clk,
   input  logic        i_reset,
   input  logic        i_enable,
   input  logic        i_trigger,
   input  logic [31:0] i_reg_mask,
   output logic        o_rd_req,
   output logic [4:0]  o_rd_addr,
   input  logic        i_rd_dv,
   input  logic [15:0] i_rd_data,
   output logic [7:0]  o_byte,
   output logic        o_byte_valid,
   input  logic        i_byte_ready,
   output logic        o_busy,
   output logic        o_scan_done,
   output logic        o_overrun
);

   localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES) + 1;

   logic [2:0]             state;
   logic [2:0]             state_nx;
   logic [TIMER_WIDTH-1:0] timer;
   logic                   pending;
   logic [31:0]            mask;
   logic [TO_W-1:0]        to_cnt;
   logic [4:0]             low_idx_c;
   logic                   tick_c;
   logic                   start_c;
   logic                   load_c;
   logic                   timeout_c;
   logic                   line_done;
   line_t                  line_c;

   assign tick_c  = i_enable && (timer == TIMER_WIDTH'(PERIOD_CYCLES - 1));
   assign start_c = tick_c || i_trigger || pending;
   assign line_c  = '{addr: o_rd_addr, data: i_rd_data, timeout: timeout_c};

   // Lowest set bit of the remaining mask.
   always_comb begin
      low_idx_c = '0;
      for (int i = 31; i >= 0; i--) begin
         if (mask[i]) low_idx_c = 5'(i);
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (i_reset) state <= ST_IDLE;
      else         state <= state_nx;
   end

   // Next state and the serializer load strobe.
   always_comb begin
      state_nx  = state;
      load_c    = 1'b0;
      timeout_c = 1'b0;
      case (state)
         ST_IDLE: if (start_c) state_nx = ST_FIND;
         ST_FIND: state_nx = (mask == '0) ? ST_DONE : ST_REQ;
         ST_REQ:  state_nx = ST_WAIT;
         ST_WAIT: begin
            if (i_rd_dv) begin
               load_c   = 1'b1;
               state_nx = ST_EMIT;
            end else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
               load_c    = 1'b1;
               timeout_c = 1'b1;
               state_nx  = ST_EMIT;
            end
         end
         ST_EMIT: if (line_done) state_nx = ST_FIND;
         ST_DONE: state_nx = ST_IDLE;
         default: state_nx = ST_IDLE;
      endcase
   end

   // Free-running period timer, held at zero while periodic mode is off.
   always_ff @(posedge clk) begin
      if (i_reset)                 timer <= '0;
      else if (!i_enable || tick_c) timer <= '0;
      else                         timer <= timer + TIMER_WIDTH'(1);
   end

   // Scan bookkeeping: pending request, mask snapshot, address and read timeout.
   always_ff @(posedge clk) begin
      if (i_reset) begin
         pending   <= 1'b0;
         mask      <= '0;
         o_rd_addr <= '0;
         to_cnt    <= '0;
      end else begin
         if (state == ST_IDLE) begin
            if (start_c) begin
               pending   <= 1'b0;
               mask      <= i_reg_mask;
               o_rd_addr <= '0;
            end
         end else if (tick_c || i_trigger) begin
            pending <= 1'b1;
         end
         if (state == ST_FIND && mask != '0) begin
            o_rd_addr <= low_idx_c;
            mask      <= mask & (mask - 32'd1);
         end
         if (state == ST_REQ)       to_cnt <= '0;
         else if (state == ST_WAIT) to_cnt <= to_cnt + TO_W'(1);
      end
   end

   // Registered status and request outputs.
   always_ff @(posedge clk) begin
      if (i_reset) begin
         o_rd_req    <= 1'b0;
         o_busy      <= 1'b0;
         o_scan_done <= 1'b0;
         o_overrun   <= 1'b0;
      end else begin
         o_rd_req    <= (state_nx == ST_REQ);
         o_busy      <= (state_nx != ST_IDLE);
         o_scan_done <= (state_nx == ST_DONE);
         o_overrun   <= tick_c && (state != ST_IDLE);
      end
   end

   line_serializer u_ser (
      .clk          (clk),
      .i_reset      (i_reset),
      .line_load    (load_c),
      .line_in      (line_c),
      .o_byte       (o_byte),
      .o_byte_valid (o_byte_valid),
      .i_byte_ready (i_byte_ready),
      .line_done    (line_done)
   );

endmodule

// File: tb/tb_mdio_reg_scanner.sv
// Scoreboard bench for mdio_reg_scanner: expected bytes/addresses queued at trigger time.
module tb_mdio_reg_scanner;

   localparam int unsigned PERIOD = 50;
   localparam int unsigned TMO    = 16;

   logic        clk = 1'b0;
   logic        i_reset;
   logic        i_enable;
   logic        i_trigger;
   logic [31:0] i_reg_mask;
   logic        o_rd_req;
   logic [4:0]  o_rd_addr;
   logic        i_rd_dv;
   logic [15:0] i_rd_data;
   logic [7:0]  o_byte;
   logic        o_byte_valid;
   logic        i_byte_ready;
   logic        o_busy;
   logic        o_scan_done;
   logic        o_overrun;

   always #5 clk = ~clk;

   mdio_reg_scanner #(.PERIOD_CYCLES(PERIOD), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .i_reset(i_reset), .i_enable(i_enable), .i_trigger(i_trigger),
      .i_reg_mask(i_reg_mask), .o_rd_req(o_rd_req), .o_rd_addr(o_rd_addr),
      .i_rd_dv(i_rd_dv), .i_rd_data(i_rd_data), .o_byte(o_byte),
      .o_byte_valid(o_byte_valid), .i_byte_ready(i_byte_ready), .o_busy(o_busy),
      .o_scan_done(o_scan_done), .o_overrun(o_overrun)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   string      hex_digits = "0123456789ABCDEF";
   logic [7:0] sb_q[$];
   logic [4:0] addr_q[$];
   logic [15:0] phy_regs [32];

   int  rdy_mode = 0;
   bit  man_ready = 1'b0;
   bit  resp_en = 1'b1;
   int  resp_lat = 1;
   int  n_req = 0, extra_req = 0, last_req_cyc = 0;
   int  n_bytes = 0, extra_bytes = 0, last_rise_cyc = 0;
   int  done_cnt = 0, last_done_cyc = 0, ovr_cnt = 0;
   int  trig_cyc = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic push_line(input logic [4:0] a, input logic [15:0] d, input bit tmo);
      sb_q.push_back(8'(hex_digits[int'(a[4])]));
      sb_q.push_back(8'(hex_digits[int'(a[3:0])]));
      sb_q.push_back(8'h3A);
      for (int s = 12; s >= 0; s = s - 4)
         sb_q.push_back(tmo ? 8'h58 : 8'(hex_digits[int'((d >> s) & 16'hF)]));
      sb_q.push_back(8'h0A);
   endtask

   task automatic push_scan(input logic [31:0] m, input bit tmo);
      for (int i = 0; i < 32; i++) begin
         if (m[i]) begin
            addr_q.push_back(5'(i));
            push_line(5'(i), phy_regs[i], tmo);
         end
      end
   endtask

   task automatic trigger();
      @(posedge clk); #1;
      i_trigger = 1'b1;
      trig_cyc  = cyc;
      @(posedge clk); #1;
      i_trigger = 1'b0;
   endtask

   task automatic wait_done(input int target, input int budget, input string tag);
      int n = 0;
      while (done_cnt < target && n < budget) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_done_seen"}, 32'(done_cnt >= target), 32'd1);
   endtask

   // Cycle counter.
   initial forever begin
      @(posedge clk);
      cyc = cyc + 1;
   end

   // Byte-ready pattern generator.
   initial begin
      int ph = 0;
      i_byte_ready = 1'b1;
      forever begin
         @(posedge clk); #2;
         ph++;
         case (rdy_mode)
            0:       i_byte_ready = 1'b1;
            1:       i_byte_ready = (ph % 3 == 0);
            2:       i_byte_ready = (ph % 8 == 0);
            default: i_byte_ready = man_ready;
         endcase
      end
   end

   // MDIO engine model: checks the address and answers with phy_regs after resp_lat cycles.
   initial begin
      logic [4:0] a;
      i_rd_dv   = 1'b0;
      i_rd_data = '0;
      forever begin
         @(negedge clk);
         if (!i_reset && o_rd_req) begin
            n_req++;
            last_req_cyc = cyc;
            a = o_rd_addr;
            if (addr_q.size() == 0) extra_req++;
            else check("rd_addr", 32'(a), 32'(addr_q.pop_front()));
            if (resp_en) begin
               repeat (resp_lat) @(posedge clk);
               #1;
               i_rd_dv   = 1'b1;
               i_rd_data = phy_regs[a];
               @(posedge clk); #1;
               i_rd_dv   = 1'b0;
               i_rd_data = '0;
            end
         end
      end
   end

   // Output monitor: byte scoreboard, stall stability, done/overrun counting.
   initial begin
      bit         prev_stall = 1'b0;
      bit         prev_valid = 1'b0;
      logic [7:0] prev_byte  = '0;
      forever begin
         @(negedge clk);
         if (i_reset) begin
            prev_stall = 1'b0;
            prev_valid = 1'b0;
         end else begin
            if (o_scan_done) begin
               done_cnt++;
               last_done_cyc = cyc;
            end
            if (o_overrun) ovr_cnt++;
            if (prev_stall) begin
               check("stall_valid", 32'(o_byte_valid), 32'd1);
               check("stall_byte", 32'(o_byte), 32'(prev_byte));
            end
            if (o_byte_valid && !prev_valid) last_rise_cyc = cyc;
            if (o_byte_valid && i_byte_ready) begin
               n_bytes++;
               if (sb_q.size() == 0) extra_bytes++;
               else check("byte", 32'(o_byte), 32'(sb_q.pop_front()));
            end
            prev_stall = o_byte_valid && !i_byte_ready;
            prev_valid = o_byte_valid;
            prev_byte  = o_byte;
         end
      end
   end

   // Global time limit.
   initial begin
      #500_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int base_done, base_req, base_bytes, base_ovr, n, d;
      i_reset    = 1'b1;
      i_enable   = 1'b0;
      i_trigger  = 1'b0;
      i_reg_mask = '0;
      for (int i = 0; i < 32; i++) phy_regs[i] = 16'h0F00 + 16'(i * 37);
      phy_regs[0]  = 16'h1234;
      phy_regs[1]  = 16'hABCD;
      phy_regs[8]  = 16'h5E7C;
      phy_regs[31] = 16'hBEEF;

      // Reset values.
      repeat (3) @(posedge clk);
      #1 i_reset = 1'b0;
      @(negedge clk);
      check("rst_rd_req", 32'(o_rd_req), 32'd0);
      check("rst_rd_addr", 32'(o_rd_addr), 32'd0);
      check("rst_byte", 32'(o_byte), 32'd0);
      check("rst_valid", 32'(o_byte_valid), 32'd0);
      check("rst_busy", 32'(o_busy), 32'd0);
      check("rst_done", 32'(o_scan_done), 32'd0);
      check("rst_overrun", 32'(o_overrun), 32'd0);

      // Two registers, ready always high.
      base_done = done_cnt;
      rdy_mode = 0; resp_lat = 1;
      i_reg_mask = 32'h0000_0003;
      push_scan(i_reg_mask, 1'b0);
      trigger();
      i_reg_mask = 32'hFFFF_FFFF;   // must not affect the running scan
      wait_done(base_done + 1, 300, "two_regs");
      repeat (5) @(negedge clk);
      check("two_regs_done_cnt", 32'(done_cnt - base_done), 32'd1);
      check("two_regs_sb_empty", 32'(sb_q.size()), 32'd0);

      // Top register, ready 1-of-3.
      base_done = done_cnt;
      rdy_mode = 1; resp_lat = 3;
      i_reg_mask = 32'h8000_0000;
      push_scan(i_reg_mask, 1'b0);
      trigger();
      wait_done(base_done + 1, 300, "reg31");
      check("reg31_sb_empty", 32'(sb_q.size()), 32'd0);

      // Read timeout.
      base_done = done_cnt;
      rdy_mode = 0; resp_en = 1'b0;
      i_reg_mask = 32'h0000_0010;
      push_scan(i_reg_mask, 1'b1);
      trigger();
      wait_done(base_done + 1, 300, "tmo");
      n = last_rise_cyc - last_req_cyc;
      check("tmo_latency_window", 32'(n >= int'(TMO) && n <= int'(TMO) + 2), 32'd1);
      check("tmo_sb_empty", 32'(sb_q.size()), 32'd0);
      resp_en = 1'b1;

      // Empty mask.
      base_done = done_cnt; base_req = n_req; base_bytes = n_bytes;
      i_reg_mask = '0;
      trigger();
      wait_done(base_done + 1, 50, "empty");
      check("empty_done_latency", 32'(last_done_cyc - trig_cyc), 32'd2);
      check("empty_no_req", 32'(n_req - base_req), 32'd0);
      check("empty_no_bytes", 32'(n_bytes - base_bytes), 32'd0);

      // Periodic mode with slow consumer: overrun and one queued scan.
      base_done = done_cnt; base_req = n_req; base_ovr = ovr_cnt;
      rdy_mode = 2; resp_lat = 1;
      i_reg_mask = 32'h0000_0001;
      push_scan(i_reg_mask, 1'b0);
      push_scan(i_reg_mask, 1'b0);
      @(posedge clk); #1 i_enable = 1'b1;
      n = 0;
      while (ovr_cnt == base_ovr && n < 400) begin
         @(negedge clk);
         n++;
      end
      check("ovr_seen", 32'(ovr_cnt - base_ovr), 32'd1);
      @(posedge clk); #1 i_enable = 1'b0;
      wait_done(base_done + 1, 400, "per1");
      d = last_done_cyc;
      n = 0;
      while (n_req < base_req + 2 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("pend_start_latency", 32'(last_req_cyc - d), 32'd3);
      wait_done(base_done + 2, 400, "per2");
      repeat (120) @(negedge clk);
      check("per_ovr_cnt", 32'(ovr_cnt - base_ovr), 32'd1);
      check("per_done_cnt", 32'(done_cnt - base_done), 32'd2);
      check("per_req_cnt", 32'(n_req - base_req), 32'd2);
      check("per_sb_empty", 32'(sb_q.size()), 32'd0);

      // Reset while the fourth character is waiting.
      base_bytes = n_bytes;
      rdy_mode = 3; man_ready = 1'b0;
      i_reg_mask = 32'h0000_0100;
      push_scan(i_reg_mask, 1'b0);
      trigger();
      n = 0;
      while (!o_byte_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("rst_mid_valid_seen", 32'(o_byte_valid), 32'd1);
      @(posedge clk); #1 man_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 man_ready = 1'b0;
      @(negedge clk);
      check("rst_mid_three_sent", 32'(n_bytes - base_bytes), 32'd3);
      check("rst_mid_char3", 32'(o_byte), 32'(sb_q[0]));
      @(posedge clk); #1 i_reset = 1'b1;
      @(posedge clk); #1 i_reset = 1'b0;
      @(negedge clk);
      check("rst_mid_valid_low", 32'(o_byte_valid), 32'd0);
      check("rst_mid_busy_low", 32'(o_busy), 32'd0);
      check("rst_mid_left", 32'(sb_q.size()), 32'd5);
      sb_q.delete();
      rdy_mode = 0;
      repeat (20) @(negedge clk);
      check("rst_mid_no_more", 32'(n_bytes - base_bytes), 32'd3);
      base_done = done_cnt;
      push_scan(i_reg_mask, 1'b0);
      trigger();
      wait_done(base_done + 1, 200, "after_rst");
      check("after_rst_sb_empty", 32'(sb_q.size()), 32'd0);

      repeat (10) @(negedge clk);
      check("extra_bytes", 32'(extra_bytes), 32'd0);
      check("extra_req", 32'(extra_req), 32'd0);
      check("addr_q_empty", 32'(addr_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mdio_reg_scanner.md
Name: mdio_reg_scanner

Overview:
- Periodically or on demand, scans a runtime-selectable set of the 32 MDIO PHY registers.
- Reads each selected register through the existing MDIO read engine's request/data-valid interface.
- Streams one ASCII line per register, "AA:DDDD\n" (uppercase hex), over a byte valid/ready handshake to the UART transmitter.
- Sits between a PHY register reader (e.g. vsc8541_register) and uart_tx; replaces fixed-delay byte pacing with a real handshake.

Parameters:
- PERIOD_CYCLES, 1_000_000, cycles between scan starts when i_enable=1 (start-to-start); must be >= 2.
- TIMEOUT_CYCLES, 4096, max cycles to wait for i_rd_dv before declaring a register read failed.
- TIMER_WIDTH, $clog2(PERIOD_CYCLES)+1, width of the period counter.

Ports:
- clk  input  1  clock.
- i_reset  input  1  reset, synchronous, active-high.
- i_enable  input  1  periodic scan mode enable.
- i_trigger  input  1  single-cycle pulse; requests one scan.
- i_reg_mask  input  32  bit n set = include register n; sampled at scan start.
- o_rd_req  output  1  one-cycle read request to the MDIO engine.
- o_rd_addr  output  5  register address; valid with o_rd_req, held until dv or timeout.
- i_rd_dv  input  1  read data valid pulse.
- i_rd_data  input  16  register contents, valid with i_rd_dv.
- o_byte  output  8  ASCII character to the UART.
- o_byte_valid  output  1  o_byte is valid.
- i_byte_ready  input  1  UART accepts the byte (i.e. !busy).
- o_busy  output  1  scan in progress (state != IDLE).
- o_scan_done  output  1  one-cycle pulse when a scan completes.
- o_overrun  output  1  one-cycle pulse when a period tick lands during a scan.

Behaviour:
- Reset: state=IDLE; timer=0; pending=0; mask register=0.
- Outputs at reset: o_rd_req=0, o_rd_addr=0, o_byte=0, o_byte_valid=0, o_busy=0, o_scan_done=0, o_overrun=0.
- Reset mid-scan aborts immediately. No further bytes are emitted, and any in-flight i_rd_dv is ignored.

Period timer:
- Counts only while i_enable=1; cleared to 0 while i_enable=0.
- Tick when timer==PERIOD_CYCLES-1, then wraps to 0.

Scan start conditions:
- A start request is: a tick, or i_trigger, or pending=1.
- Request arriving in IDLE: scan starts next cycle.
- Request arriving while busy: sets pending (collapses to one pending scan). A tick while busy also pulses o_overrun.
- Tick and i_trigger in the same cycle count as one request.

States:
- IDLE: on a start request, latch i_reg_mask, clear pending, set idx=0, go to FIND.
- FIND: if mask==0, go to DONE. Otherwise set idx to the lowest set bit and clear that bit in the mask (single cycle, priority encoder), then go to REQ.
- REQ: assert o_rd_req for exactly 1 cycle with o_rd_addr=idx, clear the timeout counter, go to WAIT.
- WAIT:
  - On i_rd_dv, capture i_rd_data and go to EMIT. The earliest accepted dv is the cycle after REQ.
  - If the timeout counter reaches TIMEOUT_CYCLES, set the data field to the ASCII text "XXXX" and go to EMIT.
- EMIT: send 8 characters (char 0..7) in order:
  - hex(idx[4]) — always '0' or '1'
  - hex(idx[3:0])
  - ':'
  - hex(d[15:12]), hex(d[11:8]), hex(d[7:4]), hex(d[3:0])
  - 0x0A
  - After char 7 is accepted: go to FIND.
- DONE: pulse o_scan_done for 1 cycle, go to IDLE. A pending request then starts from IDLE on the next cycle.

Byte handshake:
- A byte transfers on a cycle where o_byte_valid && i_byte_ready.
- While valid && !ready, o_byte must hold stable.
- Valid may assert in the cycle after entering EMIT. Back-to-back transfers at 1 byte/cycle must be supported.

Other rules:
- hex: 0-9 → 0x30-0x39, A-F → 0x41-0x46.
- i_rd_dv outside WAIT is ignored.
- i_reg_mask changes mid-scan have no effect.

Decomposition:
- Package mdio_scan_pkg:
  - state enum {IDLE, FIND, REQ, WAIT, EMIT, DONE}
  - function hex_ascii(logic [3:0]) returning logic [7:0]
  - constants CHAR_COLON=8'h3A, CHAR_NL=8'h0A, CHAR_X=8'h58, LINE_LEN=8
- Sub-module line_serializer:
  - Takes a 5-bit address, 16-bit data and a timeout flag on a load strobe.
  - Emits the 8-char line through the valid/ready handshake and returns a line_done pulse.
  - The top level holds the timer, pending logic, priority-encoder FSM and MDIO handshake.

Test Plan:
- Mask=32'h0000_0003, trigger, dv returns 16'h1234 then 16'hABCD, ready tied 1 → bytes "00:1234\n01:ABCD\n", one o_scan_done pulse, o_rd_addr 0 then 1.
- Mask=32'h8000_0000, ready toggling 1-of-3 cycles → "1F:" + data + "\n" exactly once; o_byte stable across every stall cycle; no duplicated or dropped chars.
- Mask=32'h0000_0010, no i_rd_dv, TIMEOUT_CYCLES=16 → "04:XXXX\n" emitted 16 cycles after o_rd_req; scan completes.
- PERIOD_CYCLES=50, i_enable=1, mask=32'h1, stalled ready so each scan lasts >50 cycles:
  - o_overrun pulses on the tick during the scan.
  - Exactly one queued scan starts right after o_scan_done.
- Mask=0 → trigger gives o_scan_done 2 cycles later, no bytes, no o_rd_req.
- i_reset asserted during EMIT char 3 → o_byte_valid=0 next cycle; a subsequent trigger produces a full clean line.
